detection_centroid: RTL and testbench

- Downstream consumer of the per-pixel colour-match flag produced by the colour detection stage in the DE2 CCD video path.
- Accumulates the coordinates of matched pixels over one frame. At frame end it computes the centroid with a multi-cycle restoring divider.
- Publishes centroid X/Y, matched-pixel count, a found flag and a 4-bit direction enable for the steering logic.

---
 rtl/detection_pkg.sv | 22 ++
 rtl/detection_centroid_seq_divider.sv | 75 +++++++
 rtl/detection_centroid.sv | 231 +++++++++++++++++++++++
 tb/tb_detection_centroid.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/detection_pkg.sv
// rtl/detection_pkg.sv - shared constants for the detection centroid block
// Purpose: FSM state encodings, default frame geometry, accumulator/divider
//          width and the direction-enable bit positions.
// Ports:   none (package)
package detection_pkg;

  localparam int ACC_W          = 28;
  localparam int H_ACTIVE_DEF   = 640;
  localparam int V_ACTIVE_DEF   = 480;
  localparam int MIN_PIXELS_DEF = 16;

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_DIV_X = 2'd1;
  localparam logic [1:0] ST_DIV_Y = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int EN_LEFT  = 0;
  localparam int EN_RIGHT = 1;
  localparam int EN_UP    = 2;
  localparam int EN_DOWN  = 3;

endpackage

// File: rtl/detection_centroid_seq_divider.sv
// rtl/detection_centroid_seq_divider.sv - restoring divider, one quotient bit per cycle
// Purpose: W-bit unsigned restoring division, MSB first, exactly W cycles.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               load dividend/divisor (has priority over a running step)
//   dividend, divisor   operands sampled on start
//   done                high in the cycle that produces the final quotient bit
//   quotient            low OUT_W bits of the quotient as it stands after this cycle
module seq_divider #(
  parameter int W     = 28,
  parameter int OUT_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     dividend,
  input  logic [W-1:0]     divisor,
  output logic             done,
  output logic [OUT_W-1:0] quotient
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] STEPS = CW'(W);

  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W:0]    trial;
  logic          ge;
  logic [W-1:0]  rem_step;
  logic [W-1:0]  quo_step;

  always_comb begin
    // The remainder is always below the divisor, so the W-bit difference is exact.
    trial    = {rem_q, quo_q[W-1]};
    ge       = trial >= {1'b0, dvs_q};
    rem_step = ge ? (trial[W-1:0] - dvs_q) : trial[W-1:0];
    quo_step = {quo_q[W-2:0], ge};

    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    if (start) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
      cnt_d = STEPS;
    end else if (cnt_q != '0) begin
      quo_d = quo_step;
      rem_d = rem_step;
      cnt_d = cnt_q - 1'b1;
    end

    done     = (cnt_q == CW'(1));
    quotient = quo_step[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/detection_centroid.sv
// rtl/detection_centroid.sv - per-frame centroid of colour-matched pixels
// Purpose: accumulate matched pixel coordinates over a frame, divide at vsync
//          fall and publish centroid, count, found flag and direction enables.
// Ports:
//   CLK, Reset          clock, synchronous active-high reset
//   X, Y, pix_en        pixel position and strobe
//   match_in            colour-match flag for the current pixel
//   VGA_VS              vertical sync (active low); its falling edge ends a frame
//   run                 1 = tracking, 0 = calibration (no accumulation)
//   centroid_x/_y       last computed centroid
//   pixel_count         matched pixels in the last completed frame
//   found               last frame met MIN_PIXELS
//   centroid_valid      one-cycle pulse when the outputs update
//   busy                divider running
//   overrun             one-cycle pulse when a frame end is dropped
//   enable              left/right/up/down flags from the centroid
module detection_centroid
  import detection_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int MIN_PIXELS = MIN_PIXELS_DEF
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [10:0] X,
  input  logic [10:0] Y,
  input  logic        pix_en,
  input  logic        match_in,
  input  logic        VGA_VS,
  input  logic        run,
  output logic [10:0] centroid_x,
  output logic [10:0] centroid_y,
  output logic [20:0] pixel_count,
  output logic        found,
  output logic        centroid_valid,
  output logic        busy,
  output logic        overrun,
  output logic [3:0]  enable
);

  localparam logic [10:0] H_LIM   = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM   = 11'(V_ACTIVE);
  localparam logic [10:0] H_HALF  = 11'(H_ACTIVE / 2);
  localparam logic [10:0] V_HALF  = 11'(V_ACTIVE / 2);
  localparam logic [20:0] MIN_CNT = 21'(MIN_PIXELS);

  logic             vs_d_q, vs_d_d;
  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
  logic [20:0]      cnt_q, cnt_d;
  logic [ACC_W-1:0] snap_y_q, snap_y_d;
  logic [20:0]      snap_cnt_q, snap_cnt_d;
  logic             divided_q, divided_d;
  logic [10:0]      qx_q, qx_d, qy_q, qy_d;
  logic [10:0]      cx_q, cx_d, cy_q, cy_d;
  logic [20:0]      pc_q, pc_d;
  logic             found_q, found_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             ovr_q, ovr_d;
  logic [3:0]       en_q, en_d;

  logic             frame_end;
  logic             qual;
  logic [ACC_W-1:0] x_ext, y_ext;
  logic             div_start;
  logic [ACC_W-1:0] div_dividend, div_divisor;
  logic             div_done;
  logic [10:0]      div_quotient;

  seq_divider #(.W(ACC_W), .OUT_W(11)) u_div (
    .clk      (CLK),
    .reset    (Reset),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_comb begin
    frame_end = vs_d_q & ~VGA_VS;
    qual      = pix_en & match_in & run & (X < H_LIM) & (Y < V_LIM);
    x_ext     = {{(ACC_W-11){1'b0}}, X};
    y_ext     = {{(ACC_W-11){1'b0}}, Y};

    vs_d_d     = VGA_VS;
    state_d    = state_q;
    sum_x_d    = sum_x_q;
    sum_y_d    = sum_y_q;
    cnt_d      = cnt_q;
    snap_y_d   = snap_y_q;
    snap_cnt_d = snap_cnt_q;
    divided_d  = divided_q;
    qx_d       = qx_q;
    qy_d       = qy_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    pc_d       = pc_q;
    found_d    = found_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    ovr_d      = 1'b0;
    en_d       = en_q;

    div_start    = 1'b0;
    div_dividend = sum_x_q;
    div_divisor  = {{(ACC_W-21){1'b0}}, cnt_q};

    // Accumulators restart at every frame end regardless of FSM state, and a
    // qualifying pixel on that same cycle belongs to the new frame.
    if (frame_end) begin
      sum_x_d = qual ? x_ext : '0;
      sum_y_d = qual ? y_ext : '0;
      cnt_d   = qual ? 21'd1 : 21'd0;
    end else if (qual) begin
      sum_x_d = sum_x_q + x_ext;
      sum_y_d = sum_y_q + y_ext;
      cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 21'd1;
    end

    if (frame_end && (state_q != ST_ACCUM)) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      ST_ACCUM: begin
        if (frame_end) begin
          snap_y_d   = sum_y_q;
          snap_cnt_d = cnt_q;
          if (cnt_q >= MIN_CNT) begin
            divided_d = 1'b1;
            div_start = 1'b1;
            busy_d    = 1'b1;
            state_d   = ST_DIV_X;
          end else begin
            divided_d = 1'b0;
            state_d   = ST_DONE;
          end
        end
      end
      ST_DIV_X: begin
        // Capture X's quotient on its final step and restart on Y in the same cycle.
        if (div_done) begin
          qx_d         = div_quotient;
          div_start    = 1'b1;
          div_dividend = snap_y_q;
          div_divisor  = {{(ACC_W-21){1'b0}}, snap_cnt_q};
          state_d      = ST_DIV_Y;
        end
      end
      ST_DIV_Y: begin
        if (div_done) begin
          qy_d    = div_quotient;
          state_d = ST_DONE;
        end
      end
      default: begin
        pc_d    = snap_cnt_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_ACCUM;
        if (divided_q) begin
          cx_d              = qx_q;
          cy_d              = qy_q;
          found_d           = 1'b1;
          en_d[EN_LEFT]     = qx_q < H_HALF;
          en_d[EN_RIGHT]    = qx_q >= H_HALF;
          en_d[EN_UP]       = qy_q < V_HALF;
          en_d[EN_DOWN]     = qy_q >= V_HALF;
        end else begin
          found_d = 1'b0;
          en_d    = 4'b0000;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      vs_d_q     <= 1'b1;
      state_q    <= ST_ACCUM;
      sum_x_q    <= '0;
      sum_y_q    <= '0;
      cnt_q      <= '0;
      snap_y_q   <= '0;
      snap_cnt_q <= '0;
      divided_q  <= 1'b0;
      qx_q       <= '0;
      qy_q       <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      pc_q       <= '0;
      found_q    <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
      en_q       <= '0;
    end else begin
      vs_d_q     <= vs_d_d;
      state_q    <= state_d;
      sum_x_q    <= sum_x_d;
      sum_y_q    <= sum_y_d;
      cnt_q      <= cnt_d;
      snap_y_q   <= snap_y_d;
      snap_cnt_q <= snap_cnt_d;
      divided_q  <= divided_d;
      qx_q       <= qx_d;
      qy_q       <= qy_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      pc_q       <= pc_d;
      found_q    <= found_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
      en_q       <= en_d;
    end
  end

  assign centroid_x     = cx_q;
  assign centroid_y     = cy_q;
  assign pixel_count    = pc_q;
  assign found          = found_q;
  assign centroid_valid = valid_q;
  assign busy           = busy_q;
  assign overrun        = ovr_q;
  assign enable         = en_q;

endmodule

// File: tb/tb_detection_centroid.sv
// tb/tb_detection_centroid.sv - directed self-checking bench for detection_centroid
module tb_detection_centroid;

  logic        clk;
  logic        Reset;
  logic [10:0] X, Y;
  logic        pix_en, match_in, VGA_VS, run;
  logic [10:0] centroid_x, centroid_y;
  logic [20:0] pixel_count;
  logic        found, centroid_valid, busy, overrun;
  logic [3:0]  enable;

  int n_vec = 0;
  int n_err = 0;

  detection_centroid dut (
    .CLK            (clk),
    .Reset          (Reset),
    .X              (X),
    .Y              (Y),
    .pix_en         (pix_en),
    .match_in       (match_in),
    .VGA_VS         (VGA_VS),
    .run            (run),
    .centroid_x     (centroid_x),
    .centroid_y     (centroid_y),
    .pixel_count    (pixel_count),
    .found          (found),
    .centroid_valid (centroid_valid),
    .busy           (busy),
    .overrun        (overrun),
    .enable         (enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input int y, input int n);
    for (int k = 0; k < n; k++) begin
      X = 11'(x); Y = 11'(y); pix_en = 1'b1; match_in = 1'b1;
      tick();
    end
    pix_en = 1'b0; match_in = 1'b0;
  endtask

  // Drives a vsync fall (cycle E) and watches 70 edges afterwards.
  task automatic frame_end(output int valid_at, output int n_valid,
                           output int n_ovr, output logic busy1);
    valid_at = -1; n_valid = 0; n_ovr = 0; busy1 = 1'b0;
    VGA_VS = 1'b0;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (i == 3) VGA_VS = 1'b1;
      if (i == 1) busy1 = busy;
      if (centroid_valid) begin
        n_valid++;
        if (valid_at < 0) valid_at = i;
      end
      if (overrun) n_ovr++;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      X = 11'($urandom); Y = 11'($urandom); pix_en = 1'($urandom);
      match_in = 1'($urandom); VGA_VS = 1'($urandom); run = 1'($urandom);
      tick();
      n_vec++;
      if (centroid_valid !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL reset_pulse cycle %0d got valid=%b busy=%b want 0 0", c, centroid_valid, busy);
      end
    end
    n_vec++;
    if ({centroid_x, centroid_y, pixel_count, found, overrun, enable} !== '0) begin
      n_err++; $display("FAIL reset_outputs got cx=%0d cy=%0d pc=%0d found=%b ovr=%b en=%b want all 0",
                        centroid_x, centroid_y, pixel_count, found, overrun, enable);
    end
    Reset = 1'b0; VGA_VS = 1'b1; run = 1'b1; pix_en = 1'b0; match_in = 1'b0;
    tick(); tick();
  endtask

  task automatic test_block();
    int va, nv, no; logic b1;
    for (int xi = 100; xi < 104; xi++)
      for (int yi = 50; yi < 54; yi++) send(xi, yi, 1);
    frame_end(va, nv, no, b1);
    n_vec++; if (va !== 58) begin n_err++; $display("FAIL block_latency got %0d want 58", va); end
    n_vec++; if (nv !== 1) begin n_err++; $display("FAIL block_pulses got %0d want 1", nv); end
    n_vec++; if (b1 !== 1'b1) begin n_err++; $display("FAIL block_busy got %b want 1", b1); end
    n_vec++; if (pixel_count !== 21'd16) begin n_err++; $display("FAIL block_count got %0d want 16", pixel_count); end
    n_vec++; if (centroid_x !== 11'd101) begin n_err++; $display("FAIL block_cx got %0d want 101", centroid_x); end
    n_vec++; if (centroid_y !== 11'd51) begin n_err++; $display("FAIL block_cy got %0d want 51", centroid_y); end
    n_vec++; if (found !== 1'b1) begin n_err++; $display("FAIL block_found got %b want 1", found); end
    n_vec++; if (enable !== 4'b0101) begin n_err++; $display("FAIL block_enable got %b want 0101", enable); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL block_busy_after got %b want 0", busy); end
  endtask

  task automatic test_short();
    int va, nv, no; logic b1;
    send(10, 10, 15);
    frame_end(va, nv, no, b1);
    n_vec++; if (va !== 2) begin n_err++; $display("FAIL short_latency got %0d want 2", va); end
    n_vec++; if (b1 !== 1'b0) begin n_err++; $display("FAIL short_busy got %b want 0", b1); end
    n_vec++; if (pixel_count !== 21'd15) begin n_err++; $display("FAIL short_count got %0d want 15", pixel_count); end
    n_vec++; if (found !== 1'b0) begin n_err++; $display("FAIL short_found got %b want 0", found); end
    n_vec++; if (enable !== 4'b0000) begin n_err++; $display("FAIL short_enable got %b want 0000", enable); end
    n_vec++; if (centroid_x !== 11'd101 || centroid_y !== 11'd51) begin
      n_err++; $display("FAIL short_hold got (%0d,%0d) want (101,51)", centroid_x, centroid_y);
    end
  endtask

  task automatic test_bounds();
    int va, nv, no; logic b1;
    for (int xi = 640; xi <= 700; xi++) send(xi, 10, 1);
    send(5, 480, 3);
    send(600, 400, 16);
    frame_end(va, nv, no, b1);
    n_vec++; if (va !== 58) begin n_err++; $display("FAIL bounds_latency got %0d want 58", va); end
    n_vec++; if (pixel_count !== 21'd16) begin n_err++; $display("FAIL bounds_count got %0d want 16", pixel_count); end
    n_vec++; if (centroid_x !== 11'd600 || centroid_y !== 11'd400) begin
      n_err++; $display("FAIL bounds_centroid got (%0d,%0d) want (600,400)", centroid_x, centroid_y);
    end
    n_vec++; if (enable !== 4'b1010) begin n_err++; $display("FAIL bounds_enable got %b want 1010", enable); end
  endtask

  task automatic test_overrun();
    int va, nv, no, ovr_at; logic b1;
    send(200, 100, 16);
    va = -1; no = 0; ovr_at = -1;
    VGA_VS = 1'b0;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (i == 3) VGA_VS = 1'b1;
      // Stray pixels between the two frame ends must be discarded.
      if (i >= 5 && i < 10) begin
        X = 11'd0; Y = 11'd0; pix_en = 1'b1; match_in = 1'b1;
      end else begin
        pix_en = 1'b0; match_in = 1'b0;
      end
      if (i == 20) VGA_VS = 1'b0;
      if (i == 23) VGA_VS = 1'b1;
      if (centroid_valid && va < 0) va = i;
      if (overrun) begin no++; if (ovr_at < 0) ovr_at = i; end
    end
    n_vec++; if (no !== 1) begin n_err++; $display("FAIL ovr_pulses got %0d want 1", no); end
    n_vec++; if (ovr_at !== 21) begin n_err++; $display("FAIL ovr_time got %0d want 21", ovr_at); end
    n_vec++; if (va !== 58) begin n_err++; $display("FAIL ovr_latency got %0d want 58", va); end
    n_vec++; if (centroid_x !== 11'd200 || centroid_y !== 11'd100 || pixel_count !== 21'd16) begin
      n_err++; $display("FAIL ovr_result got (%0d,%0d) n=%0d want (200,100) n=16", centroid_x, centroid_y, pixel_count);
    end
    send(300, 300, 16);
    frame_end(va, nv, no, b1);
    n_vec++; if (pixel_count !== 21'd16) begin n_err++; $display("FAIL ovr_next_count got %0d want 16", pixel_count); end
    n_vec++; if (centroid_x !== 11'd300 || centroid_y !== 11'd300) begin
      n_err++; $display("FAIL ovr_next_centroid got (%0d,%0d) want (300,300)", centroid_x, centroid_y);
    end
    n_vec++; if (enable !== 4'b1001) begin n_err++; $display("FAIL ovr_next_enable got %b want 1001", enable); end
  endtask

  task automatic test_run0_and_abort();
    int va, nv, no; logic b1;
    run = 1'b0;
    send(10, 10, 1000);
    frame_end(va, nv, no, b1);
    n_vec++; if (va !== 2) begin n_err++; $display("FAIL run0_latency got %0d want 2", va); end
    n_vec++; if (pixel_count !== 21'd0 || found !== 1'b0) begin
      n_err++; $display("FAIL run0_result got n=%0d found=%b want n=0 found=0", pixel_count, found);
    end
    run = 1'b1;
    send(50, 60, 16);
    VGA_VS = 1'b0;
    nv = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 3) VGA_VS = 1'b1;
      if (centroid_valid) nv++;
    end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_busy_before got %b want 1", busy); end
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (centroid_valid) nv++;
    end
    n_vec++; if (nv !== 0) begin n_err++; $display("FAIL abort_pulses got %0d want 0", nv); end
    n_vec++; if ({centroid_x, centroid_y, pixel_count, found, busy, overrun, enable} !== '0) begin
      n_err++; $display("FAIL abort_outputs got cx=%0d cy=%0d pc=%0d found=%b busy=%b en=%b want all 0",
                        centroid_x, centroid_y, pixel_count, found, busy, enable);
    end
  endtask

  initial begin
    Reset = 1'b1; X = '0; Y = '0; pix_en = 1'b0; match_in = 1'b0; VGA_VS = 1'b1; run = 1'b1;
    test_reset();
    test_block();
    test_short();
    test_bounds();
    test_overrun();
    test_run0_and_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
